// File: rtl/shf_pkg.sv
// Shared widths and controller state encoding for the iterating shifter controller.
package shf_pkg;
    localparam int D_W  = 4;
    localparam int OP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;
endpackage

// File: rtl/shf_iter_ctrl.sv
// Iterating controller: loads an operand, feeds shifter y back into d for in_count passes.
// Latency: N*(SETTLE+1) edges after accept (result in the cycle after accept when N=0); result held until out_ready.
module shf_iter_ctrl
    import shf_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D_W-1:0]   in_data,
    input  logic [OP_W-1:0]  in_op,
    input  logic [CNT_W-1:0] in_count,
    input  logic             abort,
    output logic [D_W-1:0]   shf_d,
    output logic [OP_W-1:0]  shf_s,
    input  logic [D_W-1:0]   shf_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_W-1:0]   out_data
);
    localparam logic [2:0] SETTLE_L = 3'(SETTLE);

    state_t           state;
    logic [D_W-1:0]   d_reg;
    logic [OP_W-1:0]  op_reg;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       wait_cnt;

    assign in_ready  = (state == IDLE) && !abort;
    assign out_valid = (state == DONE);
    assign shf_d     = d_reg;
    assign shf_s     = op_reg;
    assign out_data  = d_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            d_reg    <= '0;
            op_reg   <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !abort) begin
                        d_reg    <= in_data;
                        op_reg   <= in_op;
                        cnt      <= in_count;
                        wait_cnt <= SETTLE_L;
                        if (in_count == '0)
                            state <= DONE;
                        else if (SETTLE > 0)
                            state <= WAIT;
                        else
                            state <= RUN;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                        if (wait_cnt <= 3'd1)
                            state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        // One shifter pass per RUN edge; cnt never goes below 1 here.
                        d_reg <= shf_y;
                        cnt   <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                        end else begin
                            wait_cnt <= SETTLE_L;
                            state    <= (SETTLE > 0) ? WAIT : RUN;
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shf_iter_ctrl.sv
// Scoreboard bench: two controllers (SETTLE=0 and SETTLE=2) share stimulus, each with a rotate-left-1 stub shifter.
module tb_shf_iter_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic [2:0] in_op = '0;
    logic [3:0] in_count = '0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [3:0] shf_d_a, shf_y_a, out_data_a, shf_d_b, shf_y_b, out_data_b;
    logic [2:0] shf_s_a, shf_s_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    always #5 clk = ~clk;

    assign shf_y_a = {shf_d_a[2:0], shf_d_a[3]};
    assign shf_y_b = {shf_d_b[2:0], shf_d_b[3]};

    shf_iter_ctrl #(.CNT_W(4), .SETTLE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_op(in_op), .in_count(in_count), .abort(abort),
        .shf_d(shf_d_a), .shf_s(shf_s_a), .shf_y(shf_y_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
    );

    shf_iter_ctrl #(.CNT_W(4), .SETTLE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_op(in_op), .in_count(in_count), .abort(abort),
        .shf_d(shf_d_b), .shf_s(shf_s_b), .shf_y(shf_y_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] x, input int n);
        logic [3:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_ready_a"}, 32'(in_ready_a), 32'd1);
        check({tag, "_in_ready_b"}, 32'(in_ready_b), 32'd1);
        check({tag, "_out_valid_a"}, 32'(out_valid_a), 32'd0);
        check({tag, "_out_valid_b"}, 32'(out_valid_b), 32'd0);
    endtask

    task automatic run_job(input logic [3:0] d, input logic [2:0] op, input logic [3:0] n, input int hold);
        int lat_a, lat_b, k;
        logic [3:0] exp_a, exp_b;
        @(negedge clk);
        check("acc_in_ready_a", 32'(in_ready_a), 32'd1);
        check("acc_in_ready_b", 32'(in_ready_b), 32'd1);
        in_valid = 1'b1; in_data = d; in_op = op; in_count = n;
        q_a.push_back(rotl(d, int'(n)));
        q_b.push_back(rotl(d, int'(n)));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat_a = -1; lat_b = -1; k = 0;
        while ((lat_a < 0 || lat_b < 0) && k < 100) begin
            @(negedge clk);
            if (out_valid_a && lat_a < 0) lat_a = k;
            if (out_valid_b && lat_b < 0) lat_b = k;
            check("shf_s_a", 32'(shf_s_a), 32'(op));
            check("shf_s_b", 32'(shf_s_b), 32'(op));
            k++;
        end
        check("latency_a", 32'(lat_a), 32'(int'(n)));
        check("latency_b", 32'(lat_b), 32'(3 * int'(n)));
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_out_valid_a", 32'(out_valid_a), 32'd1);
            check("bp_out_data_a", 32'(out_data_a), 32'(exp_a));
            check("bp_in_ready_a", 32'(in_ready_a), 32'd0);
            check("bp_out_valid_b", 32'(out_valid_b), 32'd1);
            check("bp_out_data_b", 32'(out_data_b), 32'(exp_b));
            check("bp_in_ready_b", 32'(in_ready_b), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        check("out_data_a", 32'(out_data_a), 32'(exp_a));
        check("out_data_b", 32'(out_data_b), 32'(exp_b));
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check_idle("post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_shf_d", 32'(shf_d_a), 32'd0);
        check("rst_shf_s", 32'(shf_s_a), 32'd0);
        check("rst_shf_d_b", 32'(shf_d_b), 32'd0);
        rst_n = 1'b1;

        run_job(4'b0001, 3'b111, 4'd3, 0);
        run_job(4'hA,    3'b010, 4'd0, 0);
        run_job(4'b0011, 3'b101, 4'd2, 5);
        for (int j = 0; j < 4; j++)
            run_job(4'($urandom_range(15)), 3'($urandom_range(7)), 4'($urandom_range(1, 6)), j);

        // Abort while both instances are mid-job: no result may ever appear.
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'h5; in_op = 3'b001; in_count = 4'd15;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_idle("abort");
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_a || out_valid_b) saw = 1'b1;
        end
        check("abort_no_valid", 32'(saw), 32'd0);

        // abort with in_valid in IDLE: zero-count job would show out_valid if accepted.
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; in_data = 4'h9; in_count = 4'd0;
        #1;
        check("abort_idle_in_ready_a", 32'(in_ready_a), 32'd0);
        check("abort_idle_in_ready_b", 32'(in_ready_b), 32'd0);
        @(posedge clk);
        #1 abort = 1'b0; in_valid = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid_a || out_valid_b) saw = 1'b1;
        end
        check("abort_idle_no_accept", 32'(saw), 32'd0);

        // Reset mid-run.
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'h6; in_op = 3'b110; in_count = 4'd15;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        check("midrst_shf_d_a", 32'(shf_d_a), 32'd0);
        check("midrst_shf_s_a", 32'(shf_s_a), 32'd0);
        check("midrst_shf_d_b", 32'(shf_d_b), 32'd0);
        check("midrst_shf_s_b", 32'(shf_s_b), 32'd0);

        run_job(4'b1001, 3'b011, 4'd5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
